hd_mux_accumulator_64: RTL and testbench



---
 rtl/hd_mux_accumulator_64.sv | 114 +++++++++++
 tb/tb_hd_mux_accumulator_64.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hd_mux_accumulator_64.sv
// rtl/hd_mux_accumulator_64.sv - signed-select 64-lane accumulator with 3-stage adder tree
// Each lane passes or negates its feature, then the 64 lanes plus prev_result are summed.

module mux_two_one #(
    parameter int WIDTH = 8
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = i_sel ? i_a : i_b;
endmodule

module pipelined_adder_tree_64 #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0][WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0]      i_prev,
    output logic [WIDTH-1:0]      o_sum
);
    logic [31:0][WIDTH-1:0] w_l1;
    logic [15:0][WIDTH-1:0] w_l2;
    logic [7:0][WIDTH-1:0]  w_l3;
    logic [3:0][WIDTH-1:0]  w_l4;
    logic [1:0][WIDTH-1:0]  w_l5;
    logic [15:0][WIDTH-1:0] r_s1;
    logic [3:0][WIDTH-1:0]  r_s2;
    logic [WIDTH-1:0]       r_prev1;
    logic [WIDTH-1:0]       r_prev2;
    logic [WIDTH-1:0]       r_sum;

    always_comb begin
        w_l1 = '0;
        w_l2 = '0;
        for (int k = 0; k < 32; k++) w_l1[k] = i_data[2*k] + i_data[2*k+1];
        for (int k = 0; k < 16; k++) w_l2[k] = w_l1[2*k] + w_l1[2*k+1];
    end

    always_comb begin
        w_l3 = '0;
        w_l4 = '0;
        for (int k = 0; k < 8; k++) w_l3[k] = r_s1[2*k] + r_s1[2*k+1];
        for (int k = 0; k < 4; k++) w_l4[k] = w_l3[2*k] + w_l3[2*k+1];
    end

    always_comb begin
        w_l5 = '0;
        for (int k = 0; k < 2; k++) w_l5[k] = r_s2[2*k] + r_s2[2*k+1];
    end

    // prev_result rides a two-deep delay so it meets its own vector at the final add
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_prev1 <= '0;
            r_prev2 <= '0;
            r_sum   <= '0;
        end else begin
            r_s1    <= w_l2;
            r_s2    <= w_l4;
            r_prev1 <= i_prev;
            r_prev2 <= r_prev1;
            r_sum   <= w_l5[0] + w_l5[1] + r_prev2;
        end
    end

    assign o_sum = r_sum;
endmodule

module hd_mux_accumulator_64 #(
    parameter int INPUT_NUM   = 64,
    parameter int INPUT_WIDTH = 8,
    parameter int DIM_WIDTH   = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [INPUT_NUM-1:0][INPUT_WIDTH-1:0] features,
    input  logic [INPUT_NUM-1:0]                  projections,
    input  logic [DIM_WIDTH-1:0]                  prev_result,
    output logic [DIM_WIDTH-1:0]                  out
);
    logic [63:0][INPUT_WIDTH-1:0] w_neg;
    logic [63:0][INPUT_WIDTH-1:0] w_sel;
    logic [63:0][DIM_WIDTH-1:0]   w_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_lane
            // 8-bit negation wraps, so -128 stays -128
            assign w_neg[gi] = -features[gi];

            mux_two_one #(.WIDTH(INPUT_WIDTH)) u_mux (
                .i_sel (projections[gi]),
                .i_a   (features[gi]),
                .i_b   (w_neg[gi]),
                .o_y   (w_sel[gi])
            );

            assign w_ext[gi] = {{(DIM_WIDTH-INPUT_WIDTH){w_sel[gi][INPUT_WIDTH-1]}}, w_sel[gi]};
        end
    endgenerate

    pipelined_adder_tree_64 #(.WIDTH(DIM_WIDTH)) u_tree (
        .clk    (clk),
        .reset  (reset),
        .i_data (w_ext),
        .i_prev (prev_result),
        .o_sum  (out)
    );
endmodule

// File: tb/tb_hd_mux_accumulator_64.sv
// tb/tb_hd_mux_accumulator_64.sv - scoreboard bench for hd_mux_accumulator_64
// Expected sums are queued at drive time and popped when their latency elapses.

module tb_hd_mux_accumulator_64;
    logic                 clk = 1'b0;
    logic                 reset;
    logic [63:0][7:0]     features;
    logic [63:0]          projections;
    logic [15:0]          prev_result;
    logic [15:0]          out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [15:0] q_exp[$];
    int          q_due[$];
    string       q_tag[$];

    hd_mux_accumulator_64 #(
        .INPUT_NUM   (64),
        .INPUT_WIDTH (8),
        .DIM_WIDTH   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .features    (features),
        .projections (projections),
        .prev_result (prev_result),
        .out         (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [63:0][7:0] f, input logic [63:0] p,
                                          input logic [15:0] prev);
        int acc;
        logic signed [7:0] s;
        acc = 0;
        for (int i = 0; i < 64; i++) begin
            s = p[i] ? f[i] : -f[i];
            acc += int'(s);
        end
        acc += int'(prev);
        return acc[15:0];
    endfunction

    always @(negedge clk) begin
        if (q_exp.size() > 0 && q_due[0] <= cyc) begin
            check_eq(q_tag.pop_front(), out, q_exp.pop_front());
            void'(q_due.pop_front());
        end
    end

    task automatic drive(input logic [63:0][7:0] f, input logic [63:0] p,
                         input logic [15:0] prev, input logic [15:0] exp, input string tag);
        features    = f;
        projections = p;
        prev_result = prev;
        q_exp.push_back(exp);
        q_due.push_back(cyc + 3);
        q_tag.push_back(tag);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        features    = '0;
        projections = '0;
        prev_result = '0;
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (q_exp.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q_exp.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", q_exp.size());
            q_exp.delete();
            q_due.delete();
            q_tag.delete();
        end
    endtask

    logic [63:0][7:0] f_ramp, f_ten, f_min, f_one, f_rnd;
    logic [63:0]      p_rnd;
    logic [15:0]      prev_rnd;

    initial begin
        for (int i = 0; i < 64; i++) begin
            f_ramp[i] = 8'(i);
            f_ten[i]  = 8'd10;
            f_min[i]  = 8'h80;
            f_one[i]  = 8'd1;
        end

        reset       = 1'b1;
        features    = {16{32'hDEADBEEF}};
        projections = 64'hA5A5_5A5A_0F0F_F0F0;
        prev_result = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        check_eq("reset", out, 16'h0000);

        reset = 1'b0;
        drive_idle();
        check_eq("post_reset_1", out, 16'h0000);
        drive_idle();
        check_eq("post_reset_2", out, 16'h0000);

        drive(f_ramp, {64{1'b1}}, 16'd3, 16'd2019, "ramp");
        drive(f_ten,  {64{1'b1}}, 16'd3, 16'd643,  "constant");
        drive(f_ten,  {{48{1'b1}}, 16'h0000}, 16'd3, 16'd323, "mixed");
        drive(f_min,  '0, 16'h0000, 16'hE000, "neg_extreme");
        drive(f_one,  {64{1'b1}}, 16'h7FFF, 16'h803F, "wrap");

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 64; i++) f_rnd[i] = 8'($urandom);
            p_rnd    = {$urandom, $urandom};
            prev_rnd = 16'($urandom);
            drive(f_rnd, p_rnd, prev_rnd, model(f_rnd, p_rnd, prev_rnd), $sformatf("random_%0d", n));
        end
        drive('0, '0, 16'h0000, 16'h0000, "idle");
        drain();

        drive(f_ramp, {64{1'b1}}, 16'd3, 16'd2019, "pre_flush_a");
        drive(f_ten,  {64{1'b1}}, 16'd3, 16'd643,  "pre_flush_b");
        reset = 1'b1;
        q_exp.delete();
        q_due.delete();
        q_tag.delete();
        @(negedge clk);
        check_eq("flush_reset", out, 16'h0000);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive_idle();
            check_eq($sformatf("flush_after_%0d", n), out, 16'h0000);
        end

        drive(f_ten, {{48{1'b1}}, 16'h0000}, 16'd3, 16'd323, "after_flush");
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
